// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared definitions for the packed-float divider slice:
//             default-format constants, operand class encoding, canonical
//             qNaN and field-extract / classify helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_NEXP = 8;
    localparam int FP_NSIG = 7;
    localparam int FP_W    = 1 + FP_NEXP + FP_NSIG;

    localparam int                  BIAS    = 2**(FP_NEXP-1) - 1;
    localparam logic [FP_NEXP-1:0]  EXP_MAX = '1;

    // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB set.
    localparam logic [FP_W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(FP_NSIG-1){1'b0}}};

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [FP_NEXP-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: FP_NEXP];
    endfunction

    function automatic logic [FP_NSIG-1:0] fp_frac(input logic [FP_W-1:0] x);
        return x[FP_NSIG-1:0];
    endfunction

    // Width-independent classifier; subnormals (exp==0) collapse to ZERO.
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_nz);
        if (exp_zero)              return ZERO;
        else if (exp_ones && frac_nz) return NAN;
        else if (exp_ones)         return INF;
        else                       return NORM;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : fp_div_norm_round
//  Purpose  : Combinational normalise / round-to-nearest-even / pack for the
//             divider. Handles exponent overflow (-> inf) and underflow
//             (-> flush to zero).
//  Ports    : i_sign          result sign
//             i_e   [NEXP+1:0] signed biased exponent before normalisation
//             i_m   [WF+1:0]   quotient significand, 2 int + WF frac bits,
//                              in (0.5, 2)
//             o_q             packed result {sign, exp, frac}
//  Revision : 1.0 - initial release
// ============================================================================
module fp_div_norm_round #(
    parameter int NEXP = 8,
    parameter int NSIG = 7,
    parameter int WF   = 2*NSIG + 4
) (
    input  logic                   i_sign,
    input  logic signed [NEXP+1:0] i_e,
    input  logic        [WF+1:0]   i_m,
    output logic [NEXP+NSIG:0]     o_q
);

    localparam logic signed [NEXP+1:0] c_ONE     = (NEXP+2)'(1);
    localparam logic signed [NEXP+1:0] c_ZERO_E  = '0;
    localparam logic signed [NEXP+1:0] c_EXP_MAX = {2'b00, {NEXP{1'b1}}};

    logic                   w_lt1;
    logic [WF-1:0]          w_mn;      // fraction bits below the leading 1
    logic signed [NEXP+1:0] w_e_n;
    logic [NSIG-1:0]        w_frac;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_up;
    logic [NSIG:0]          w_rnd;
    logic signed [NEXP+1:0] w_e_r;

    assign w_lt1    = (i_m[WF+1:WF] == 2'b00);
    assign w_mn     = w_lt1 ? {i_m[WF-2:0], 1'b0} : i_m[WF-1:0];
    assign w_e_n    = w_lt1 ? (i_e - c_ONE) : i_e;

    assign w_frac   = w_mn[WF-1 -: NSIG];
    assign w_guard  = w_mn[WF-NSIG-1];
    assign w_sticky = |w_mn[WF-NSIG-2:0];
    assign w_up     = w_guard & (w_sticky | w_frac[0]);
    assign w_rnd    = {1'b0, w_frac} + {{NSIG{1'b0}}, w_up};

    // A rounding carry leaves the fraction field at zero (significand 2.0),
    // so renormalising only needs the exponent bump.
    assign w_e_r    = w_rnd[NSIG] ? (w_e_n + c_ONE) : w_e_n;

    always_comb begin
        o_q = {i_sign, w_e_r[NEXP-1:0], w_rnd[NSIG-1:0]};
        if (w_e_r >= c_EXP_MAX) begin
            o_q = {i_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (w_e_r <= c_ZERO_E) begin
            o_q = {i_sign, {(NEXP+NSIG){1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/reciprocal.sv
`default_nettype none
// ============================================================================
//  Module   : reciprocal
//  Purpose  : Combinational reciprocal seed for a significand in [1,2).
//             o_r is Q1.NSIG approximating 2/i_d, saturating to all-ones
//             when i_d is exactly 1.0 (where 2.0 is not representable).
//  Ports    : i_d  [NSIG:0]  significand, Q1.NSIG, hidden bit set
//             o_r  [NSIG:0]  seed, Q1.NSIG
//  Revision : 1.0 - initial release
// ============================================================================
module reciprocal #(
    parameter int NSIG = 7
) (
    input  logic [NSIG:0] i_d,
    output logic [NSIG:0] o_r
);

    localparam int              c_W   = 2*NSIG + 2;
    // 2^(2*NSIG+1): dividing by i_d (scaled by 2^NSIG) yields 2/d in Q1.NSIG.
    localparam logic [c_W-1:0]  c_NUM = {1'b1, {(c_W-1){1'b0}}};

    logic [c_W-1:0] w_quo;

    assign w_quo = c_NUM / {{(c_W-NSIG-1){1'b0}}, i_d};
    assign o_r   = (|w_quo[c_W-1:NSIG+1]) ? '1 : w_quo[NSIG:0];

endmodule
`default_nettype wire

// File: rtl/fp_div_nr.sv
`default_nettype none
// ============================================================================
//  Module   : fp_div_nr
//  Purpose  : Sequential floating-point divider Q = A / B using a reciprocal
//             seed refined by Newton-Raphson, then multiplied by A.
//             One operation in flight, valid/ready on both sides.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready / a / b     operand handshake
//             out_valid / out_ready / q       result handshake
//  Revision : 1.0 - initial release
// ============================================================================
module fp_div_nr
    import fp_pkg::*;
#(
    parameter int NEXP  = 8,
    parameter int NSIG  = 7,
    parameter int ITERS = 2,
    parameter int WF    = 2*NSIG + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   a,
    input  logic [NEXP+NSIG:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   q
);

    localparam int                     c_W      = 1 + NEXP + NSIG;
    localparam int                     c_PW1    = NSIG + WF + 2;
    localparam int                     c_PW2    = 2*WF + 3;
    localparam logic [1:0]             c_ITERS  = 2'(ITERS);
    localparam logic [WF+1:0]          c_TWO    = {2'b10, {WF{1'b0}}};
    localparam logic signed [NEXP+1:0] c_BIAS_E = (NEXP+2)'(2**(NEXP-1) - 1);
    localparam logic [c_W-1:0]         c_QNAN   = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPEC   = 3'd1,
        S_NR_MUL = 3'd2,
        S_NR_UPD = 3'd3,
        S_QMUL   = 3'd4,
        S_NORM   = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    state_e r_state, w_state_nxt;

    logic [c_W-1:0]         r_a, r_b, r_q;
    logic [WF:0]            r_x;          // 1 int + WF frac
    logic [WF+1:0]          r_t;          // 2 int + WF frac
    logic [WF+1:0]          r_m;          // 2 int + WF frac
    logic signed [NEXP+1:0] r_e;
    logic                   r_sign;
    logic [1:0]             r_iter;

    logic [NEXP-1:0]        w_ea, w_eb;
    logic [NSIG:0]          w_asig, w_bsig, w_recip;
    fp_class_e              w_cls_a, w_cls_b;
    logic                   w_sign;
    logic                   w_nan, w_inf, w_zero, w_special;
    logic [c_W-1:0]         w_spec_q, w_norm_q;
    logic [c_PW1-1:0]       w_bx, w_am;
    logic [c_PW2-1:0]       w_xc;
    logic [WF+1:0]          w_corr;
    logic [1:0]             w_iter_inc;

    // ---------------- operand fields & classification ----------------
    assign w_ea    = r_a[c_W-2 -: NEXP];
    assign w_eb    = r_b[c_W-2 -: NEXP];
    assign w_asig  = {1'b1, r_a[NSIG-1:0]};
    assign w_bsig  = {1'b1, r_b[NSIG-1:0]};
    assign w_sign  = r_a[c_W-1] ^ r_b[c_W-1];
    assign w_cls_a = fp_classify(w_ea == '0, w_ea == '1, r_a[NSIG-1:0] != '0);
    assign w_cls_b = fp_classify(w_eb == '0, w_eb == '1, r_b[NSIG-1:0] != '0);

    assign w_nan     = (w_cls_a == NAN) || (w_cls_b == NAN) ||
                       ((w_cls_a == ZERO) && (w_cls_b == ZERO)) ||
                       ((w_cls_a == INF)  && (w_cls_b == INF));
    assign w_inf     = (w_cls_a == INF)  || (w_cls_b == ZERO);
    assign w_zero    = (w_cls_a == ZERO) || (w_cls_b == INF);
    assign w_special = w_nan || w_inf || w_zero;

    always_comb begin
        w_spec_q = {w_sign, {(NEXP+NSIG){1'b0}}};
        if (w_nan)      w_spec_q = c_QNAN;
        else if (w_inf) w_spec_q = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end

    // ---------------- seed and Newton-Raphson arithmetic ----------------
    reciprocal #(.NSIG(NSIG)) u_recip (
        .i_d (w_bsig),
        .o_r (w_recip)
    );

    assign w_bx       = {{(WF+1){1'b0}}, w_bsig} * {{(NSIG+1){1'b0}}, r_x};
    assign w_am       = {{(WF+1){1'b0}}, w_asig} * {{(NSIG+1){1'b0}}, r_x};
    assign w_corr     = c_TWO - r_t;
    assign w_xc       = {{(WF+2){1'b0}}, r_x} * {{(WF+1){1'b0}}, w_corr};
    assign w_iter_inc = r_iter + 2'd1;

    fp_div_norm_round #(.NEXP(NEXP), .NSIG(NSIG), .WF(WF)) u_norm (
        .i_sign (r_sign),
        .i_e    (r_e),
        .i_m    (r_m),
        .o_q    (w_norm_q)
    );

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_SPEC;
            end
            S_SPEC:   w_state_nxt = w_special ? S_DONE : S_NR_MUL;
            S_NR_MUL: w_state_nxt = S_NR_UPD;
            S_NR_UPD: w_state_nxt = (w_iter_inc < c_ITERS) ? S_NR_MUL : S_QMUL;
            S_QMUL:   w_state_nxt = S_NORM;
            S_NORM:   w_state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_q    <= '0;
            r_x    <= '0;
            r_t    <= '0;
            r_m    <= '0;
            r_e    <= '0;
            r_sign <= 1'b0;
            r_iter <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_iter <= '0;
                    end
                end
                S_SPEC: begin
                    r_sign <= w_sign;
                    r_e    <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_BIAS_E;
                    if (w_special) r_q <= w_spec_q;
                    // x0 = R/2: the Q1.NSIG seed lands one bit lower in WF.
                    else           r_x <= {1'b0, w_recip, {(WF-NSIG-1){1'b0}}};
                end
                S_NR_MUL: r_t <= (WF+2)'(w_bx >> NSIG);
                S_NR_UPD: begin
                    r_x    <= (WF+1)'(w_xc >> WF);
                    r_iter <= w_iter_inc;
                end
                S_QMUL:   r_m <= (WF+2)'(w_am >> NSIG);
                S_NORM:   r_q <= w_norm_q;
                default: ;
            endcase
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_nr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_div_nr
//  Purpose  : Directed self-checking bench for fp_div_nr (bfloat16 default).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_div_nr;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;

    logic [15:0] sb_q[$];
    int          n_tests;
    int          n_fail;

    fp_div_nr dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operation; its expected result goes into the scoreboard.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] eq,
                            input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        sb_q.push_back(eq);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then check latency, busy in_ready and q.
    task automatic wait_out(input string tag, input int elat);
        int lat;
        bit busy_bad;
        logic [15:0] eq;
        lat      = 0;
        busy_bad = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy"}, {31'b0, busy_bad}, 32'd0);
        eq = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        check({tag, "_q"}, {16'b0, q}, {16'b0, eq});
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] eq,
                          input int elat, input string tag);
        start_op(ta, tb_, eq, tag);
        wait_out(tag, elat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] held;
        bit          unstable;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        #12;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_q",         {16'b0, q},         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal path
        run_op(16'h40C0, 16'h4040, 16'h4000, 7, "div_6_3");
        run_op(16'h3F80, 16'h4040, 16'h3EAB, 7, "div_1_3");
        run_op(16'hC0C0, 16'h4040, 16'hC000, 7, "div_m6_3");
        run_op(16'h3F80, 16'h3F80, 16'h3F80, 7, "div_1_1");

        // Specials
        run_op(16'h3F80, 16'h0000, 16'h7F80, 1, "div_1_0");
        run_op(16'h0000, 16'h0000, 16'h7FC0, 1, "div_0_0");
        run_op(16'h0000, 16'h7F80, 16'h0000, 1, "div_0_inf");
        run_op(16'hBF80, 16'h0000, 16'hFF80, 1, "div_m1_0");
        run_op(16'h7F80, 16'h7F80, 16'h7FC0, 1, "div_inf_inf");
        run_op(16'h7FC1, 16'h3F80, 16'h7FC0, 1, "div_nan_1");
        run_op(16'h3F80, 16'hFF80, 16'h8000, 1, "div_1_minf");

        // Range limits
        run_op(16'h7F00, 16'h3F00, 16'h7F80, 7, "overflow");
        run_op(16'h0080, 16'h7F00, 16'h0000, 7, "underflow");

        // Backpressure: hold out_ready low for 5 cycles after out_valid
        out_ready = 1'b0;
        start_op(16'h40C0, 16'h4040, 16'h4000, "bp");
        wait_out("bp", 7);
        held     = q;
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (q !== held || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
        end
        check("bp_hold", {31'b0, unstable}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready",  {31'b0, in_ready},  32'd1);
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

        // Reset while in NR_UPD aborts the operation
        start_op(16'h40C0, 16'h4040, 16'h4000, "abort");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'b0, in_ready},  32'd1);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h40C0, 16'h4040, 16'h4000, 7, "after_abort");

        check("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
